// File: rtl/sipo_demux8_pkg.sv
// Shared constants and state encoding for the 8-bit serial-in demux collector.
package sipo_demux8_pkg;
  localparam int WORD_W = 8;
  localparam int IDX_W  = 3;

  localparam logic [IDX_W-1:0] IDX_LAST = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;
endpackage

// File: rtl/sipo_demux8_if.sv
// Frame/bit/word handshake bundle between the serial source/word sink and the collector.
interface sipo_demux8_if;
  import sipo_demux8_pkg::*;

  logic              start;
  logic              din;
  logic              din_valid;
  logic              out_ready;
  logic [WORD_W-1:0] q;
  logic              q_valid;
  logic [IDX_W-1:0]  idx;
  logic              busy;
  logic              overrun;

  modport master (
    output start, din, din_valid, out_ready,
    input  q, q_valid, idx, busy, overrun
  );

  modport slave (
    input  start, din, din_valid, out_ready,
    output q, q_valid, idx, busy, overrun
  );
endinterface

// File: rtl/sipo_demux8_bitwrite.sv
// Index-to-one-hot write enable for the shadow word, the write-side mirror of an 8:1 mux select.
module demux8_bitwrite
  import sipo_demux8_pkg::*;
(
  input  logic [IDX_W-1:0]  sel,
  input  logic              en,
  output logic [WORD_W-1:0] we
);

  always_comb begin
    we = '0;
    if (en) we[sel] = 1'b1;
  end

endmodule

// File: rtl/sipo_demux8.sv
// Serial-in word collector: demuxes qualified bits into an 8-bit shadow, hands out full words.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no frame open; bits ignored until start
// ST_COLLECT | accepting bits into shadow[idx]
// ST_HOLD    | complete word on q, waiting for out_ready
module sipo_demux8
  import sipo_demux8_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  sipo_demux8_if.slave   bus
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] shadow_q, shadow_d;
  logic [WORD_W-1:0] q_q, q_d;
  logic              q_valid_q, q_valid_d;
  logic              overrun_q, overrun_d;

  logic              restart;
  logic              clr_shadow;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [WORD_W-1:0] wr_we;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    q_d        = q_q;
    q_valid_d  = q_valid_q;
    overrun_d  = overrun_q;
    restart    = 1'b0;
    clr_shadow = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) restart = 1'b1;
      end
      ST_COLLECT: begin
        if (bus.start) begin
          restart = 1'b1;
        end else if (bus.din_valid) begin
          wr_en = 1'b1;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            q_d       = {bus.din, shadow_q[WORD_W-2:0]};
            q_valid_d = 1'b1;
            state_d   = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          q_valid_d = 1'b0;
          state_d   = ST_IDLE;
          if (bus.start) restart = 1'b1;
        end else if (bus.din_valid) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new frame always opens at index 0, optionally capturing its first bit this cycle.
    if (restart) begin
      state_d    = ST_COLLECT;
      clr_shadow = 1'b1;
      wr_idx     = '0;
      wr_en      = bus.din_valid;
      idx_d      = bus.din_valid ? IDX_W'(1) : '0;
    end
  end

  demux8_bitwrite u_bitwrite (
    .sel (wr_idx),
    .en  (wr_en),
    .we  (wr_we)
  );

  always_comb begin
    shadow_d = clr_shadow ? '0 : shadow_q;
    shadow_d = (shadow_d & ~wr_we) | ({WORD_W{bus.din}} & wr_we);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      shadow_q  <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.q_valid = q_valid_q;
  assign bus.idx     = idx_q;
  assign bus.overrun = overrun_q;
  assign bus.busy    = (state_q == ST_COLLECT);

endmodule

// File: tb/tb_sipo_demux8.sv
// Directed scenarios plus random traffic for sipo_demux8, checked against a bit-queue model.
module tb_sipo_demux8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sipo_demux8_if bus_if ();

  sipo_demux8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int total = 0;
  int bad   = 0;

  // Model: a frame is the list of bits accepted so far; a word is that list packed LSB first.
  bit         m_active;
  bit         m_hold;
  bit         m_bits[$];
  logic [7:0] m_q;
  bit         m_qv;
  bit         m_ovr;

  task automatic model_open(input bit dv, input bit d);
    m_active = 1'b1;
    m_bits.delete();
    if (dv) m_bits.push_back(d);
  endtask

  task automatic model_step(input bit r, input bit st, input bit d, input bit dv, input bit ordy);
    if (r) begin
      m_active = 1'b0; m_hold = 1'b0; m_bits.delete();
      m_q = 8'h00; m_qv = 1'b0; m_ovr = 1'b0;
    end else if (m_hold) begin
      if (ordy) begin
        m_hold = 1'b0;
        m_qv   = 1'b0;
        if (st) model_open(dv, d);
      end else if (dv) begin
        m_ovr = 1'b1;
      end
    end else if (st) begin
      model_open(dv, d);
    end else if (m_active && dv) begin
      m_bits.push_back(d);
      if (m_bits.size() == 8) begin
        for (int i = 0; i < 8; i++) m_q[i] = m_bits[i];
        m_qv = 1'b1; m_hold = 1'b1; m_active = 1'b0;
        m_bits.delete();
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("q",       bus_if.q,                  m_q);
    chk("q_valid", {7'd0, bus_if.q_valid},    {7'd0, m_qv});
    chk("idx",     {5'd0, bus_if.idx},        8'(m_bits.size()));
    chk("busy",    {7'd0, bus_if.busy},       {7'd0, m_active});
    chk("overrun", {7'd0, bus_if.overrun},    {7'd0, m_ovr});
  endtask

  task automatic step(input bit r, input bit st, input bit d, input bit dv, input bit ordy);
    rst              = r;
    bus_if.start     = st;
    bus_if.din       = d;
    bus_if.din_valid = dv;
    bus_if.out_ready = ordy;
    model_step(r, st, d, dv, ordy);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic send_bits(input logic [7:0] w, input int first, input int last);
    for (int i = first; i <= last; i++) step(0, 0, w[i], 1, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;

    rst = 1'b1;
    bus_if.start = 1'b0; bus_if.din = 1'b0; bus_if.din_valid = 1'b0; bus_if.out_ready = 1'b0;

    // Reset then 0x7A LSB first on consecutive cycles.
    step(1, 0, 0, 0, 0);
    chk("reset_q", bus_if.q, 8'h00);
    chk("reset_busy", {7'd0, bus_if.busy}, 8'd0);
    step(0, 0, 0, 1, 0);
    chk("idle_ignores_bit_idx", {5'd0, bus_if.idx}, 8'd0);
    step(0, 1, 0, 0, 0);
    send_bits(8'h7A, 0, 7);
    chk("w7a_q", bus_if.q, 8'h7A);
    chk("w7a_qv", {7'd0, bus_if.q_valid}, 8'd1);
    chk("w7a_idx", {5'd0, bus_if.idx}, 8'd0);
    step(0, 0, 0, 0, 1);
    chk("w7a_release_qv", {7'd0, bus_if.q_valid}, 8'd0);
    chk("w7a_q_retained", bus_if.q, 8'h7A);

    // Loopback through an 8:1 mux: din = d[s], start coincides with the first bit.
    d = 8'h7A;
    for (int s = 0; s < 8; s++) begin
      chk("loop_idx", {5'd0, bus_if.idx}, 8'(s));
      step(0, (s == 0), d[s], 1, 0);
    end
    chk("loop_q", bus_if.q, 8'h7A);
    step(0, 0, 0, 0, 1);

    // Gapped din_valid every third cycle for 0xA5.
    d = 8'hA5;
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      chk("gap_idx_hold", {5'd0, bus_if.idx}, 8'(i));
      step(0, 0, d[i], 1, 0);
    end
    chk("gap_q", bus_if.q, 8'hA5);
    step(0, 0, 0, 0, 1);

    // Restart after four bits of 0xFF, then 0x0F.
    step(0, 1, 0, 0, 0);
    send_bits(8'hFF, 0, 3);
    step(0, 1, 0, 0, 0);
    chk("restart_idx", {5'd0, bus_if.idx}, 8'd0);
    send_bits(8'h0F, 0, 7);
    chk("restart_q", bus_if.q, 8'h0F);
    step(0, 0, 0, 0, 1);

    // start wins over the idx=7 completion; then HOLD + out_ready + start reopens at idx 0.
    step(0, 1, 0, 0, 0);
    send_bits(8'hFF, 0, 6);
    step(0, 1, 0, 1, 0);
    chk("prio_qv", {7'd0, bus_if.q_valid}, 8'd0);
    chk("prio_idx", {5'd0, bus_if.idx}, 8'd1);
    send_bits(8'hFE, 1, 7);
    chk("prio_q", bus_if.q, 8'hFE);
    step(0, 1, 1, 1, 1);
    chk("hold_restart_busy", {7'd0, bus_if.busy}, 8'd1);
    chk("hold_restart_idx", {5'd0, bus_if.idx}, 8'd1);
    send_bits(8'h01, 1, 7);
    chk("hold_restart_q", bus_if.q, 8'h01);
    step(0, 0, 0, 0, 1);

    // 0x3C held while bits keep arriving: overrun sticks.
    step(0, 1, 0, 0, 0);
    send_bits(8'h3C, 0, 7);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1'($urandom), 1'(i % 2 == 0), 0);
      chk("hold_q_stable", bus_if.q, 8'h3C);
    end
    chk("overrun_set", {7'd0, bus_if.overrun}, 8'd1);
    step(0, 0, 0, 0, 1);
    chk("overrun_release_qv", {7'd0, bus_if.q_valid}, 8'd0);
    chk("overrun_sticky", {7'd0, bus_if.overrun}, 8'd1);

    // Reset mid-frame and in HOLD, then a clean 0x81.
    step(0, 1, 0, 0, 0);
    send_bits(8'hFF, 0, 4);
    step(1, 0, 1, 1, 1);
    chk("rst_mid_idx", {5'd0, bus_if.idx}, 8'd0);
    chk("rst_mid_ovr", {7'd0, bus_if.overrun}, 8'd0);
    step(0, 1, 0, 0, 0);
    send_bits(8'h55, 0, 7);
    step(1, 1, 1, 1, 0);
    chk("rst_hold_q", bus_if.q, 8'h00);
    chk("rst_hold_qv", {7'd0, bus_if.q_valid}, 8'd0);
    step(0, 1, 0, 0, 0);
    send_bits(8'h81, 0, 7);
    chk("after_rst_q", bus_if.q, 8'h81);
    step(0, 0, 0, 0, 1);

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 19) == 0),
           1'($urandom),
           ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 9) < 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sipo_demux8.md
SIPO_DEMUX8 -- requirements
Module: sipo_demux8

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 Port rst  input  1  synchronous active-high reset, sampled on clk rising edge.
REQ-004 Port start  input  1  frame start; begins a new 8-bit collection at index 0.
REQ-005 Port din  input  1  serial data bit, routed to word position idx.
REQ-006 Port din_valid  input  1  din qualifier; one bit accepted per cycle when high and accepting.
REQ-007 Port out_ready  input  1  downstream accepts q when high with q_valid.
REQ-008 Port q  output  8  assembled word; bit i = i-th accepted bit (LSB first).
REQ-009 Port q_valid  output  1  q holds a complete word.
REQ-010 Port idx  output  3  demux index that the next accepted bit will be written to.
REQ-011 Port busy  output  1  high in COLLECT state.
REQ-012 Port overrun  output  1  sticky; din_valid seen while holding an unread word.

Function
REQ-013 States SHALL be IDLE, COLLECT, HOLD, encoded 2 bits; the unused encoding SHALL return to IDLE.
REQ-014 IDLE: start=1 -> COLLECT, idx<=0, shadow<=0; din_valid without start SHALL be ignored.
REQ-015 If start and din_valid are both high in IDLE, din SHALL be written to shadow[0] and idx SHALL become 1.
REQ-016 COLLECT: on din_valid, shadow[idx]<=din and idx<=idx+1 (mod 8); din_valid low SHALL leave state and idx unchanged.
REQ-017 COLLECT with idx=7 and din_valid: q<={din, shadow[6:0]}, q_valid<=1, idx<=0 (wrap), -> HOLD; q_valid SHALL be visible the cycle after the 8th accepted bit.
REQ-018 start in COLLECT SHALL discard the partial word: idx<=0, shadow<=0 (plus REQ-015 capture if din_valid high); start has priority over the idx=7 completion.
REQ-019 HOLD: q and q_valid SHALL be stable until out_ready=1; out_ready=1 SHALL clear q_valid next cycle and go to IDLE.
REQ-020 HOLD with out_ready and start in the same cycle SHALL go directly to COLLECT at idx 0 (bit captured per REQ-015).
REQ-021 din_valid in HOLD without out_ready SHALL set overrun and drop the bit; overrun SHALL clear only on rst.
REQ-022 q SHALL retain its last value after q_valid falls; q changes only on word completion.
REQ-023 busy SHALL equal (state==COLLECT), combinational from the state register.

Reset
REQ-024 rst SHALL force state=IDLE, idx=0, shadow=0, q=0x00, q_valid=0, overrun=0, busy=0 on the next clk edge.
REQ-025 rst SHALL take priority over all other inputs, including mid-collection and in HOLD; partial words SHALL be lost.

Structure
REQ-026 A shared package SHALL hold the state encoding constants (ST_IDLE=0, ST_COLLECT=1, ST_HOLD=2) and WORD_W=8, IDX_W=3.
REQ-027 One sub-module, demux8_bitwrite (3-bit index + bit -> 8-bit one-hot write enable), SHALL implement the shadow write decode, mirroring mux8 selection.
REQ-028 All outputs except busy SHALL be registered.

Verification
REQ-029 Reset, start, then bits of 0x7A LSB first (0,1,0,1,1,1,1,0) on consecutive cycles -> q=0x7A, q_valid=1 one cycle after 8th bit, idx=0.
REQ-030 Loopback: mux8 driven with d=0x7A, s stepping 0..7, y fed to din -> q=0x7A; for each s, idx equals s when that bit is accepted.
REQ-031 Gapped din_valid (high every 3rd cycle) for 0xA5 -> q=0xA5, idx holds during gaps.
REQ-032 start after 4 bits of 0xFF, then 8 bits of 0x0F -> q=0x0F, no trace of first partial word.
REQ-033 Word 0x3C held with out_ready=0 for 5 cycles while din_valid pulses -> q stable 0x3C, overrun=1; out_ready=1 -> q_valid=0 next cycle, overrun stays 1.
REQ-034 rst asserted after 5 bits and again in HOLD -> all outputs per REQ-024 next cycle; following full frame 0x81 -> q=0x81.
